// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT WIDTH-bit event counters with sticky overflow, clear, preset and a tear-free 32-bit read port.
// Read latency is 1 cycle and the port is never stalled: every rd_en produces rd_valid on the next edge.
module perf_counter_bank #(
    parameter int NUM_CNT = 4,
    parameter int WIDTH   = 64,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CNT-1:0] evt,
    input  logic               freeze,
    input  logic               clr_all,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_hi,
    input  logic [31:0]        wr_data,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic               rd_hi,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic [NUM_CNT-1:0] ovf
);

    localparam int HW = WIDTH - 32;
    localparam logic [IDX_W:0] NCNT = (IDX_W+1)'(NUM_CNT);

    logic [WIDTH-1:0]   cnt [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_q;

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = wr_en && ({1'b0, wr_idx} < NCNT);
    assign rd_ok = {1'b0, rd_idx} < NCNT;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
        localparam logic [IDX_W-1:0] ID = IDX_W'(i);

        logic [WIDTH-1:0] c_q;
        logic             o_q;
        logic             sel;

        assign sel = wr_ok && (wr_idx == ID);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                c_q <= '0;
                o_q <= 1'b0;
            end else if (clr_all) begin
                c_q <= '0;
                o_q <= 1'b0;
            end else if (sel) begin
                // a preset always wins over a same-cycle event on this channel
                if (wr_hi)
                    c_q[WIDTH-1:32] <= wr_data[HW-1:0];
                else
                    c_q[31:0] <= wr_data;
                o_q <= 1'b0;
            end else if (evt[i] && !freeze) begin
                c_q <= c_q + WIDTH'(1);
                if (&c_q)
                    o_q <= 1'b1;
            end
        end

        assign cnt[i]   = c_q;
        assign ovf_q[i] = o_q;
    end

    assign ovf = ovf_q;

    // read mux; out-of-range indices select zero
    logic [WIDTH-1:0] rd_cnt;

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_idx == IDX_W'(i))
                rd_cnt = cnt[i];
        end
    end

    logic [HW-1:0]    shadow_hi;
    logic [IDX_W-1:0] shadow_idx;
    logic             shadow_vld;

    logic             cap;
    logic             use_sh;
    logic             kill;
    logic [IDX_W-1:0] sh_idx_nxt;

    assign cap        = rd_en && rd_ok && !rd_hi;
    assign use_sh     = rd_en && rd_ok && rd_hi && shadow_vld && (rd_idx == shadow_idx);
    assign sh_idx_nxt = cap ? rd_idx : shadow_idx;
    // a same-cycle write or clear makes any captured high half stale
    assign kill       = clr_all || (wr_ok && (wr_idx == sh_idx_nxt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            shadow_hi  <= '0;
            shadow_idx <= '0;
            shadow_vld <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!rd_ok)
                    rd_data <= '0;
                else if (!rd_hi)
                    rd_data <= rd_cnt[31:0];
                else if (use_sh)
                    rd_data <= 32'(shadow_hi);
                else
                    rd_data <= 32'(rd_cnt[WIDTH-1:32]);
            end
            if (cap) begin
                shadow_hi  <= rd_cnt[WIDTH-1:32];
                shadow_idx <= rd_idx;
            end
            shadow_vld <= (cap || (shadow_vld && !use_sh)) && !kill;
        end
    end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised bank of NUM_CNT event counters. It generalises the single 32-bit retired-instruction counter into multi-channel, WIDTH-bit counters with per-channel event inputs, a global freeze, clear and preset, sticky overflow flags, and a tear-free 32-bit read port. It sits beside the core and counts cycles, retired instructions, stalls, branch mispredicts and similar events. The MMIO/CSR decoder drives its read and write ports.

Parameters:
NUM_CNT, 4, number of counter channels (1..16)
WIDTH, 64, counter width in bits (33..64); bits above WIDTH read as zero
IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_CNT

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-high reset
evt  in  NUM_CNT  per-channel increment strobe; bit i adds 1 to counter i
freeze  in  1  global hold; while high, no counter increments
clr_all  in  1  synchronous clear of all counters and overflow flags
wr_en  in  1  preset strobe
wr_idx  in  IDX_W  channel to preset
wr_hi  in  1  0 = write bits [31:0], 1 = write bits [WIDTH-1:32]
wr_data  in  32  preset data
rd_en  in  1  read request
rd_idx  in  IDX_W  channel to read
rd_hi  in  1  0 = low word, 1 = high word
rd_data  out  32  read data, valid when rd_valid is high
rd_valid  out  1  one-cycle strobe, 1 clock after rd_en
ovf  out  NUM_CNT  sticky overflow flag per channel

Behaviour:
- Reset, asynchronous: all counters = 0, ovf = 0, rd_data = 0, rd_valid = 0, shadow_hi = 0, shadow_vld = 0.
- Per channel i, each cycle. Priority is highest first:
  1. clr_all: counter = 0, ovf[i] = 0.
  2. wr_en && wr_idx == i: the selected half is replaced by wr_data (truncated to WIDTH-32 bits for the high half); the other half is held; ovf[i] = 0.
  3. evt[i] && !freeze: counter += 1 modulo 2**WIDTH.
  4. Otherwise hold.
- A write to a channel in the same cycle as its event: the write wins and the event is dropped.
- Overflow: an increment from all-ones wraps the counter to 0 and sets ovf[i] = 1. ovf[i] stays set until clr_all or any write to channel i.
- freeze does not block clr_all or wr_en.
- wr_idx or rd_idx >= NUM_CNT:
  - a write has no effect;
  - a read returns 0 with rd_valid = 1 and does not touch the shadow.
- Read latency is 1 cycle. rd_data and rd_valid are registered. When rd_en is low, rd_valid = 0 and rd_data holds its last value.
- Read values reflect the counter before any update in the same cycle.
- Tear-free read:
  - A low-word read (rd_hi = 0) returns counter[31:0]. In the same edge it captures counter[WIDTH-1:32] into shadow_hi, sets shadow_idx = rd_idx and shadow_vld = 1.
  - A high-word read with shadow_vld && rd_idx == shadow_idx returns shadow_hi and clears shadow_vld.
  - Any other high-word read returns the live counter[WIDTH-1:32] zero-extended.
  - clr_all, or any write to channel shadow_idx, clears shadow_vld.
- A single port serves at most one read per cycle. Reads and writes may occur in the same cycle.

Test Plan:
- Basic count: reset, then pulse evt[0] for 10 cycles and evt[2] for 3 cycles (not contiguous) -> read ch0 low = 10, ch2 low = 3, ch1 = 0; rd_valid high exactly 1 cycle after each rd_en.
- Freeze and priority:
  - freeze=1 while evt=4'hF for 5 cycles -> all counters unchanged.
  - wr_en to ch1 low with 32'h55 and evt[1]=1 in the same cycle -> ch1 low reads 32'h55.
- Wrap and overflow: preset ch3 to 64'hFFFF_FFFF_FFFF_FFFE, give 2 events -> counter reads 0, ovf[3]=1; ovf[3] stays 1 after 5 further events; a write to ch3 high clears it.
- Tear-free read:
  - ch0 = 64'h0000_0001_FFFF_FFFF; read low (evt[0] held high, so the counter rolls to 64'h2_0000_0000), then read high -> low = FFFF_FFFF, high = 1 (shadow).
  - A second high read -> 2 (live).
- Async reset mid-operation: assert rst between clock edges while counting and during a pending read -> counters, ovf, rd_valid and rd_data are 0 immediately, without waiting for a clock edge; counting resumes from 0 after deassertion.
- Out-of-range index with NUM_CNT=4: read idx 7 -> 0 and rd_valid=1; write idx 5 -> no counter or ovf change.
